bin2onehot_stream: RTL and testbench

Streaming, registered successor to the combinational binary-to-one-hot decoder. It accepts binary codes over a valid/ready handshake and decodes each one to one-hot or thermometer form, selected per beat. It flags codes that do not fit the output width and keeps a saturating error count. It sits between a code-producing stage and a consumer that can apply backpressure, and sustains full throughput through a 2-entry skid buffer.

---
 rtl/bin2onehot_stream.sv | 117 +++++++++++
 tb/tb_bin2onehot_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bin2onehot_stream.sv
// bin2onehot_stream: valid/ready binary-to-one-hot/thermometer decoder with a
// 2-entry skid buffer (OUT + SKID) and a saturating out-of-range error count.
module bin2onehot_stream #(
  parameter int unsigned BIN_W     = 4,
  parameter int unsigned ONE_HOT_W = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [BIN_W-1:0]     bin_i,
  input  logic                 mode_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ONE_HOT_W-1:0] one_hot_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  // Stored payload: decoded vector plus its out-of-range flag.
  typedef struct packed {
    logic [ONE_HOT_W-1:0] one_hot;
    logic                 err;
  } beat_t;

  beat_t                out_q, out_d;
  beat_t                skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  beat_t                dec;
  int unsigned          code;
  logic                 in_range;
  logic                 in_fire;
  logic                 out_fire;

  // Ready is derived from SKID occupancy only, never from out_ready_i.
  assign in_ready_o = !skid_valid_q && !reset;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;

  // Decode the incoming code before it is registered.
  always_comb begin
    code        = 32'(bin_i);
    in_range    = (code < ONE_HOT_W);
    dec.one_hot = '0;
    dec.err     = !in_range;
    for (int unsigned i = 0; i < ONE_HOT_W; i++) begin
      if (mode_i) begin
        dec.one_hot[i] = in_range && (i <= code);
      end else begin
        dec.one_hot[i] = in_range && (i == code);
      end
    end
  end

  // Next-state for OUT/SKID storage and the saturating error counter.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (skid_valid_q) begin
      if (out_fire) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
        if (in_fire) begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end
    end else if (in_fire) begin
      if (!out_valid_q || out_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire && dec.err && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  // State registers with synchronous reset; in-flight beats are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign one_hot_o   = out_q.one_hot;
  assign err_o       = out_q.err;
  assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_bin2onehot_stream.sv
// Scoreboard bench for bin2onehot_stream with a narrow output (10 bits) and a
// 2-bit error counter so that out-of-range codes and saturation are exercised.
module tb_bin2onehot_stream;

  localparam int unsigned BIN_W     = 4;
  localparam int unsigned ONE_HOT_W = 10;
  localparam int unsigned ERR_CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIN_W-1:0]     bin;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ONE_HOT_W-1:0] one_hot;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  bin2onehot_stream #(
    .BIN_W(BIN_W), .ONE_HOT_W(ONE_HOT_W), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .bin_i(bin), .mode_i(mode),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .one_hot_o(one_hot), .err_o(err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] sb[$];
  int          model_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: {err, vector} from plain arithmetic on the code value.
  function automatic logic [31:0] expect_beat(input int b, input bit m);
    if (b >= int'(ONE_HOT_W)) return 32'(1) << ONE_HOT_W;
    if (m) return (32'(1) << (b + 1)) - 32'(1);
    return 32'(1) << b;
  endfunction

  // Monitor: samples mid-cycle, so values seen equal those at the next edge.
  always @(negedge clk) begin
    if (reset) begin
      check("ready_in_reset", 32'(in_ready), 32'd0);
      sb.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      check("err_cnt", 32'(err_cnt), 32'(model_cnt));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      if (prev_stall)
        check("hold_stable", {31'(0), out_valid} | (32'({err, one_hot}) << 1),
              32'd1 | (prev_beat << 1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_beat", 32'({err, one_hot}), 32'hFFFF_FFFF);
        else check("beat", 32'({err, one_hot}), sb.pop_front());
      end
      if (in_valid && in_ready) begin
        sb.push_back(expect_beat(int'(bin), mode));
        if (int'(bin) >= int'(ONE_HOT_W) && model_cnt < (1 << ERR_CNT_W) - 1) model_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = 32'({err, one_hot});
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int b, input bit m);
    bit acc;
    int guard;
    in_valid = 1'b1;
    bin      = BIN_W'(b);
    mode     = m;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset     = 1'b1;
    in_valid  = 1'b0;
    bin       = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);
    check("reset_out", 32'({out_valid, err, one_hot, err_cnt}), 32'd0);
    @(posedge clk); #1;

    // Back-to-back stream of every code in one-hot mode.
    for (int b = 0; b < 16; b++) send(b, 1'b0);
    idle(3);

    // Thermometer mode, including an out-of-range code.
    send(0, 1'b1); send(5, 1'b1); send(9, 1'b1); send(15, 1'b1); send(3, 1'b1);
    idle(3);

    // Stall: codes 1, 2 fill OUT and SKID, code 3 waits.
    out_ready = 1'b0;
    send(1, 1'b0);
    send(2, 1'b0);
    in_valid = 1'b1; bin = BIN_W'(3); mode = 1'b0;
    @(negedge clk);
    check("skid_full_ready", 32'(in_ready), 32'd0);
    check("stalled_head", 32'(one_hot), 32'h002);
    idle(4);
    out_ready = 1'b1;
    send(3, 1'b0);
    idle(4);

    // Saturation from a cleared counter: 1, 2, 3, 3, 3.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      send(10 + k, k[0]);
      idle(1);
    end
    check("sat_final", 32'(err_cnt), 32'd3);
    idle(2);

    // Reset with both registers full and counter saturated.
    out_ready = 1'b0;
    send(12, 1'b0);
    send(4, 1'b1);
    @(negedge clk);
    check("full_before_reset", 32'({in_ready, out_valid, err_cnt}), 32'b0_1_11);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_clear", 32'({out_valid, err, one_hot, err_cnt}), 32'd0);
    check("after_reset_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Random traffic with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Drain everything that is still stored.
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    guard      = 0;
    while (sb.size() != 0 && guard < 20) begin idle(1); guard++; end
    @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
